// File: rtl/const_bank_pkg.sv
// Shared definitions for the constant bank: default geometry, index-width helper
// and the reset-value rule (each entry powers up holding its own index).
// Pure package, no logic; latency and backpressure do not apply.
package const_bank_pkg;

    localparam int DEF_WIDTH     = 16;
    localparam int DEF_NUM_CONST = 8;

    // Smallest r with 2**r >= n (returns 0 for n <= 1).
    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < n) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

    localparam int DEF_SEL_W = clog2(DEF_NUM_CONST);

    // Entry i resets to i; the caller casts to WIDTH, which zero-extends or truncates.
    function automatic logic [31:0] reset_value(input int idx);
        return 32'(idx);
    endfunction

endpackage

// File: rtl/const_bank_entry.sv
// One constant slot: WIDTH-bit value register plus a sticky write-protect bit.
// Latency: a qualified write lands on the next rising edge; the lock takes effect the same edge.
// No backpressure: strobes are single-cycle and always consumed.
//
// Ports:
//   i_clk, i_reset  clock and synchronous active-high reset
//   i_wr_sel        write strobe already decoded for this slot
//   i_lock_sel      lock strobe already decoded for this slot
//   i_wr_data       write data
//   o_value         current stored value
//   o_locked        current lock bit
module const_bank_entry
    import const_bank_pkg::*;
#(
    parameter int               WIDTH      = DEF_WIDTH,
    parameter logic [WIDTH-1:0] RESET_VAL  = '0,
    parameter logic             RESET_LOCK = 1'b0
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_wr_sel,
    input  logic             i_lock_sel,
    input  logic [WIDTH-1:0] i_wr_data,
    output logic [WIDTH-1:0] o_value,
    output logic             o_locked
);

    logic [WIDTH-1:0] r_value;
    logic             r_lock;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_value <= RESET_VAL;
            r_lock  <= RESET_LOCK;
        end else begin
            // Write is qualified by the lock bit as it stood before this edge,
            // so a simultaneous write+lock on an open slot still lands.
            if (i_wr_sel && !r_lock) begin
                r_value <= i_wr_data;
            end
            if (i_lock_sel) begin
                r_lock <= 1'b1;
            end
        end
    end

    assign o_value  = r_value;
    assign o_locked = r_lock;

endmodule

// File: rtl/const_bank.sv
// Parametrised bank of datapath constants with run-time rewritable, lockable entries.
// Latency: read data/valid and write ack/err appear one cycle after the request.
// No backpressure: one read and one write accepted every cycle; all outputs registered.
//
// Ports:
//   i_clk, i_reset   clock and synchronous active-high reset
//   i_rd_en, i_sel   read request and index (index >= NUM_CONST reads as 0)
//   o_data, o_valid  registered read data; valid for a read issued the previous cycle
//   i_wr_en, i_wr_addr, i_wr_data  write request, index (also lock index), data
//   i_lock           set the sticky lock bit of entry i_wr_addr
//   o_wr_ack, o_wr_err  one-cycle pulses: write accepted / rejected
module const_bank
    import const_bank_pkg::*;
#(
    parameter int                   WIDTH     = DEF_WIDTH,
    parameter int                   NUM_CONST = DEF_NUM_CONST,
    parameter int                   SEL_W     = DEF_SEL_W,
    parameter logic [NUM_CONST-1:0] LOCK_MASK = NUM_CONST'(3)
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_rd_en,
    input  logic [SEL_W-1:0] i_sel,
    output logic [WIDTH-1:0] o_data,
    output logic             o_valid,
    input  logic             i_wr_en,
    input  logic [SEL_W-1:0] i_wr_addr,
    input  logic [WIDTH-1:0] i_wr_data,
    input  logic             i_lock,
    output logic             o_wr_ack,
    output logic             o_wr_err
);

    // One extra bit so NUM_CONST itself is representable for the range compare.
    localparam logic [SEL_W:0] NUM_CONST_W = (SEL_W + 1)'(NUM_CONST);

    logic [WIDTH-1:0] w_entry_val [NUM_CONST];
    logic             w_entry_lock [NUM_CONST];
    logic [WIDTH-1:0] w_rd_val;
    logic             w_addr_locked;
    logic             w_wr_in_range;
    logic             w_wr_ok;

    logic [WIDTH-1:0] r_data;
    logic             r_valid;
    logic             r_wr_ack;
    logic             r_wr_err;

    genvar g;
    generate
        for (g = 0; g < NUM_CONST; g++) begin : g_entry
            logic w_hit;
            assign w_hit = (i_wr_addr == SEL_W'(g));

            const_bank_entry #(
                .WIDTH      (WIDTH),
                .RESET_VAL  (WIDTH'(reset_value(g))),
                .RESET_LOCK (LOCK_MASK[g])
            ) u_entry (
                .i_clk      (i_clk),
                .i_reset    (i_reset),
                .i_wr_sel   (i_wr_en && w_hit),
                .i_lock_sel (i_lock && w_hit),
                .i_wr_data  (i_wr_data),
                .o_value    (w_entry_val[g]),
                .o_locked   (w_entry_lock[g])
            );
        end
    endgenerate

    // Read mux: indices with no matching entry fall through to zero.
    always_comb begin
        w_rd_val = '0;
        for (int i = 0; i < NUM_CONST; i++) begin
            if (i_sel == SEL_W'(i)) begin
                w_rd_val = w_entry_val[i];
            end
        end
    end

    // Lock bit of the addressed entry, before any lock applied this cycle.
    always_comb begin
        w_addr_locked = 1'b0;
        for (int i = 0; i < NUM_CONST; i++) begin
            if (i_wr_addr == SEL_W'(i)) begin
                w_addr_locked = w_entry_lock[i];
            end
        end
    end

    assign w_wr_in_range = ({1'b0, i_wr_addr} < NUM_CONST_W);
    assign w_wr_ok       = w_wr_in_range && !w_addr_locked;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_data   <= '0;
            r_valid  <= 1'b0;
            r_wr_ack <= 1'b0;
            r_wr_err <= 1'b0;
        end else begin
            r_valid  <= i_rd_en;
            if (i_rd_en) begin
                r_data <= w_rd_val;
            end
            r_wr_ack <= i_wr_en && w_wr_ok;
            r_wr_err <= i_wr_en && !w_wr_ok;
        end
    end

    assign o_data   = r_data;
    assign o_valid  = r_valid;
    assign o_wr_ack = r_wr_ack;
    assign o_wr_err = r_wr_err;

endmodule

// File: tb/tb_const_bank.sv
module tb_const_bank;

    logic        clk = 1'b0;
    logic        rst;
    logic        rd_en;
    logic [2:0]  sel;
    logic        wr_en;
    logic [2:0]  wr_addr;
    logic [15:0] wr_data;
    logic        lock;

    logic [15:0] a_data;
    logic        a_valid, a_ack, a_err;
    logic [15:0] b_data;
    logic        b_valid, b_ack, b_err;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    // Default geometry: 8 entries, entries 0 and 1 locked.
    const_bank #(.WIDTH(16), .NUM_CONST(8), .SEL_W(3), .LOCK_MASK(8'h03)) dut_a (
        .i_clk(clk), .i_reset(rst), .i_rd_en(rd_en), .i_sel(sel),
        .o_data(a_data), .o_valid(a_valid),
        .i_wr_en(wr_en), .i_wr_addr(wr_addr), .i_wr_data(wr_data), .i_lock(lock),
        .o_wr_ack(a_ack), .o_wr_err(a_err)
    );

    // Non-power-of-two geometry: 6 entries behind a 3-bit index.
    const_bank #(.WIDTH(16), .NUM_CONST(6), .SEL_W(3), .LOCK_MASK(6'h03)) dut_b (
        .i_clk(clk), .i_reset(rst), .i_rd_en(rd_en), .i_sel(sel),
        .o_data(b_data), .o_valid(b_valid),
        .i_wr_en(wr_en), .i_wr_addr(wr_addr), .i_wr_data(wr_data), .i_lock(lock),
        .o_wr_ack(b_ack), .o_wr_err(b_err)
    );

    typedef struct {
        logic        rst;
        logic        rd;
        logic [2:0]  sel;
        logic        wr;
        logic [2:0]  addr;
        logic [15:0] wdat;
        logic        lk;
        logic        exp_v;
        logic [15:0] exp_d;
        logic        exp_ack;
        logic        exp_err;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic r, input logic rd_i, input logic [2:0] s,
                                input logic w, input logic [2:0] a, input logic [15:0] d,
                                input logic l, input logic ev, input logic [15:0] ed,
                                input logic eack, input logic eerr);
        vec_t v;
        v.rst = r; v.rd = rd_i; v.sel = s; v.wr = w; v.addr = a; v.wdat = d; v.lk = l;
        v.exp_v = ev; v.exp_d = ed; v.exp_ack = eack; v.exp_err = eerr;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Drive one cycle of inputs, let the edge take them, sample just after the edge.
    task automatic step(input logic r, input logic rd_i, input logic [2:0] s,
                        input logic w, input logic [2:0] a, input logic [15:0] d,
                        input logic l);
        @(negedge clk);
        rst = r; rd_en = rd_i; sel = s; wr_en = w; wr_addr = a; wr_data = d; lock = l;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; rd_en = 1'b0; sel = '0; wr_en = 1'b0; wr_addr = '0; wr_data = '0; lock = 1'b0;

        //                 rst rd sel wr adr data      lk   v  data      ack err
        vecs.push_back(mk(1, 0, 0, 0, 0, 16'h0000, 0,  0, 16'h0000, 0, 0)); // reset state
        vecs.push_back(mk(1, 1, 1, 1, 2, 16'h1111, 0,  0, 16'h0000, 0, 0)); // reset beats rd/wr
        vecs.push_back(mk(0, 1, 1, 0, 0, 16'h0000, 0,  1, 16'h0001, 0, 0)); // legacy constant 1
        for (int i = 0; i < 8; i++)
            vecs.push_back(mk(0, 1, 3'(i), 0, 0, 16'h0000, 0, 1, 16'(i), 0, 0)); // back-to-back
        vecs.push_back(mk(0, 0, 0, 0, 0, 16'h0000, 0,  0, 16'h0007, 0, 0)); // idle: O holds
        vecs.push_back(mk(0, 0, 0, 1, 1, 16'h00FF, 0,  0, 16'h0007, 0, 1)); // locked entry 1
        vecs.push_back(mk(0, 1, 1, 0, 0, 16'h0000, 0,  1, 16'h0001, 0, 0)); // still 1
        vecs.push_back(mk(0, 1, 4, 1, 4, 16'hBEEF, 0,  1, 16'h0004, 1, 0)); // read-before-write
        vecs.push_back(mk(0, 1, 4, 0, 0, 16'h0000, 0,  1, 16'hBEEF, 0, 0)); // new value visible
        vecs.push_back(mk(0, 0, 0, 1, 5, 16'h0002, 1,  0, 16'hBEEF, 1, 0)); // write+lock succeeds
        vecs.push_back(mk(0, 0, 0, 1, 5, 16'h0003, 0,  0, 16'hBEEF, 0, 1)); // now locked
        vecs.push_back(mk(0, 1, 5, 0, 0, 16'h0000, 0,  1, 16'h0002, 0, 0));
        vecs.push_back(mk(1, 0, 0, 0, 0, 16'h0000, 0,  0, 16'h0000, 0, 0)); // reset clears lock
        vecs.push_back(mk(0, 1, 5, 0, 0, 16'h0000, 0,  1, 16'h0005, 0, 0));
        vecs.push_back(mk(0, 0, 0, 1, 5, 16'h0003, 0,  0, 16'h0005, 1, 0));
        vecs.push_back(mk(0, 1, 5, 0, 0, 16'h0000, 0,  1, 16'h0003, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 6, 16'h0000, 1,  0, 16'h0003, 0, 0)); // lock alone: no pulse
        vecs.push_back(mk(0, 0, 0, 1, 6, 16'h1234, 0,  0, 16'h0003, 0, 1));
        vecs.push_back(mk(0, 1, 6, 0, 0, 16'h0000, 0,  1, 16'h0006, 0, 0));
        vecs.push_back(mk(0, 1, 3, 1, 2, 16'hA5A5, 0,  1, 16'h0003, 1, 0)); // rd/wr different idx
        vecs.push_back(mk(0, 1, 2, 0, 0, 16'h0000, 0,  1, 16'hA5A5, 0, 0));
        vecs.push_back(mk(0, 0, 0, 1, 0, 16'h5555, 0,  0, 16'hA5A5, 0, 1)); // entry 0 locked
        vecs.push_back(mk(0, 1, 0, 0, 0, 16'h0000, 0,  1, 16'h0000, 0, 0));

        foreach (vecs[k]) begin
            step(vecs[k].rst, vecs[k].rd, vecs[k].sel, vecs[k].wr, vecs[k].addr,
                 vecs[k].wdat, vecs[k].lk);
            chk($sformatf("row%0d data", k),  32'(a_data),  32'(vecs[k].exp_d));
            chk($sformatf("row%0d valid", k), 32'(a_valid), 32'(vecs[k].exp_v));
            chk($sformatf("row%0d ack", k),   32'(a_ack),   32'(vecs[k].exp_ack));
            chk($sformatf("row%0d err", k),   32'(a_err),   32'(vecs[k].exp_err));
        end

        // Six-entry bank: out-of-range reads and writes.
        step(1, 0, 0, 0, 0, 16'h0000, 0);
        chk("b reset valid", 32'(b_valid), 32'(0));
        chk("b reset data",  32'(b_data),  32'(0));
        step(0, 1, 5, 0, 0, 16'h0000, 0);
        chk("b sel5 data",  32'(b_data),  32'(5));
        step(0, 1, 7, 0, 0, 16'h0000, 0);
        chk("b sel7 data",  32'(b_data),  32'(0));
        chk("b sel7 valid", 32'(b_valid), 32'(1));
        chk("a sel7 data",  32'(a_data),  32'(7));
        step(0, 1, 6, 0, 0, 16'h0000, 0);
        chk("b sel6 data",  32'(b_data),  32'(0));
        chk("b sel6 valid", 32'(b_valid), 32'(1));
        step(0, 0, 0, 1, 6, 16'h1111, 0);
        chk("b wr6 err", 32'(b_err), 32'(1));
        chk("b wr6 ack", 32'(b_ack), 32'(0));
        chk("a wr6 ack", 32'(a_ack), 32'(1));
        chk("a wr6 err", 32'(a_err), 32'(0));
        step(0, 0, 0, 1, 7, 16'h2222, 1);
        chk("b wr7 err", 32'(b_err), 32'(1));
        chk("a wr7+lock ack", 32'(a_ack), 32'(1));
        step(0, 0, 0, 1, 7, 16'h3333, 0);
        chk("a wr7 after lock err", 32'(a_err), 32'(1));
        chk("a wr7 after lock ack", 32'(a_ack), 32'(0));

        // Reset alongside requests drops them.
        step(1, 1, 3, 0, 0, 16'h0000, 0);
        chk("b rst+rd valid", 32'(b_valid), 32'(0));
        chk("a rst+rd valid", 32'(a_valid), 32'(0));
        step(1, 0, 0, 1, 3, 16'h4444, 0);
        chk("a rst+wr ack", 32'(a_ack), 32'(0));
        chk("a rst+wr err", 32'(a_err), 32'(0));
        step(0, 1, 3, 0, 0, 16'h0000, 0);
        chk("a dropped write data", 32'(a_data), 32'(3));
        chk("b sel3 data",          32'(b_data), 32'(3));
        step(0, 1, 7, 0, 0, 16'h0000, 0);
        chk("a lock cleared data", 32'(a_data), 32'(7));
        step(0, 0, 0, 0, 0, 16'h0000, 0);
        chk("a idle valid", 32'(a_valid), 32'(0));
        chk("a idle ack",   32'(a_ack),   32'(0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
